// File: rtl/accumulator_write_arbiter.sv
// Round-robin arbiter that shares the accumulator write port between ALU writeback (req0) and memory load (req1).
// It supports locked bursts, and all accumulator-side outputs come from registers.
module accumulator_write_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_SEL_WIDTH = 2,
    parameter int MAX_BURST     = 4,
    localparam int CNT_W        = $clog2(MAX_BURST + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0Valid,
    output logic                     req0Ready,
    input  logic [REG_SEL_WIDTH-1:0] req0Reg,
    input  logic [DATA_WIDTH-1:0]    req0Data,
    input  logic                     req0Lock,
    input  logic                     req1Valid,
    output logic                     req1Ready,
    input  logic [REG_SEL_WIDTH-1:0] req1Reg,
    input  logic [DATA_WIDTH-1:0]    req1Data,
    input  logic                     req1Lock,
    output logic                     regWrite,
    output logic [REG_SEL_WIDTH-1:0] RegisterNumber,
    output logic [DATA_WIDTH-1:0]    writeData,
    output logic                     grantId,
    output logic                     busy,
    output logic [1:0]               dbgState,
    output logic [CNT_W-1:0]         dbgBurstCnt
);

    // Handshake: a write transfers in a cycle when reqXValid && reqXReady; ready is
    // combinational, only ever asserted alongside valid, and at most one ready is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arbStateT;

    arbStateT         state, stateNext;
    logic [CNT_W-1:0] burstCnt, cntNext, cntPlusOne;
    logic             lastGrant, lastNext;
    logic             grant0, grant1;

    assign cntPlusOne = burstCnt + CNT_W'(1);

    always_comb begin
        stateNext = state;
        cntNext   = burstCnt;
        lastNext  = lastGrant;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (state == OWN0 && req0Lock) begin
            if (req0Valid) begin
                grant0   = 1'b1;
                lastNext = 1'b0;
                if (cntPlusOne >= CNT_W'(MAX_BURST)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cntPlusOne;
                end
            end
        end else if (state == OWN1 && req1Lock) begin
            if (req1Valid) begin
                grant1   = 1'b1;
                lastNext = 1'b1;
                if (cntPlusOne >= CNT_W'(MAX_BURST)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cntPlusOne;
                end
            end
        end else begin
            // Plain round-robin; a dropped lock lands here too, with lastGrant already the owner.
            stateNext = IDLE;
            cntNext   = '0;
            if (req0Valid && (!req1Valid || lastGrant)) begin
                grant0 = 1'b1;
            end else if (req1Valid) begin
                grant1 = 1'b1;
            end
            if (grant0) begin
                lastNext = 1'b0;
                if (req0Lock && MAX_BURST > 1) begin
                    stateNext = OWN0;
                    cntNext   = CNT_W'(1);
                end
            end else if (grant1) begin
                lastNext = 1'b1;
                if (req1Lock && MAX_BURST > 1) begin
                    stateNext = OWN1;
                    cntNext   = CNT_W'(1);
                end
            end
        end
    end

    // Reset must suppress any handshake in the same cycle.
    assign req0Ready   = grant0 && reset;
    assign req1Ready   = grant1 && reset;
    assign busy        = (state != IDLE);
    assign dbgState    = state;
    assign dbgBurstCnt = burstCnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            burstCnt       <= '0;
            lastGrant      <= 1'b1;
            regWrite       <= 1'b0;
            RegisterNumber <= '0;
            writeData      <= '0;
            grantId        <= 1'b0;
        end else begin
            state     <= stateNext;
            burstCnt  <= cntNext;
            lastGrant <= lastNext;
            regWrite  <= grant0 | grant1;
            if (grant0) begin
                RegisterNumber <= req0Reg;
                writeData      <= req0Data;
                grantId        <= 1'b0;
            end else if (grant1) begin
                RegisterNumber <= req1Reg;
                writeData      <= req1Data;
                grantId        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_write_arbiter.sv
// Directed bench for accumulator_write_arbiter: hand-computed ready/state per cycle, with a
// queue of expected {grantId, RegisterNumber, writeData} words for the registered write side.
module tb_accumulator_write_arbiter;

    localparam int W = 11;
    localparam logic [1:0] stIdle = 2'd0;
    localparam logic [1:0] stOwn0 = 2'd1;
    localparam logic [1:0] stOwn1 = 2'd2;

    logic       clock;
    logic       reset;
    logic       req0Valid, req0Ready, req0Lock;
    logic [1:0] req0Reg;
    logic [7:0] req0Data;
    logic       req1Valid, req1Ready, req1Lock;
    logic [1:0] req1Reg;
    logic [7:0] req1Data;
    logic       regWrite;
    logic [1:0] RegisterNumber;
    logic [7:0] writeData;
    logic       grantId;
    logic       busy;
    logic [1:0] dbgState;
    logic [2:0] dbgBurstCnt;

    logic [W-1:0] expQ[$];
    int checkCount = 0;
    int errCount   = 0;

    accumulator_write_arbiter #(
        .DATA_WIDTH(8),
        .REG_SEL_WIDTH(2),
        .MAX_BURST(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req0Valid(req0Valid),
        .req0Ready(req0Ready),
        .req0Reg(req0Reg),
        .req0Data(req0Data),
        .req0Lock(req0Lock),
        .req1Valid(req1Valid),
        .req1Ready(req1Ready),
        .req1Reg(req1Reg),
        .req1Data(req1Data),
        .req1Lock(req1Lock),
        .regWrite(regWrite),
        .RegisterNumber(RegisterNumber),
        .writeData(writeData),
        .grantId(grantId),
        .busy(busy),
        .dbgState(dbgState),
        .dbgBurstCnt(dbgBurstCnt)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic l0, input logic [1:0] r0, input logic [7:0] d0,
                         input logic v1, input logic l1, input logic [1:0] r1, input logic [7:0] d1);
        req0Valid = v0; req0Lock = l0; req0Reg = r0; req0Data = d0;
        req1Valid = v1; req1Lock = l1; req1Reg = r1; req1Data = d1;
    endtask

    // One clock: check readies for the driven inputs, then the registered result and next state.
    task automatic cycle(input logic e0, input logic e1, input logic [1:0] expState);
        logic [W-1:0] word;
        #1;
        checkVal("req0Ready", {31'd0, req0Ready}, {31'd0, e0});
        checkVal("req1Ready", {31'd0, req1Ready}, {31'd0, e1});
        if (e0) expQ.push_back({1'b0, req0Reg, req0Data});
        else if (e1) expQ.push_back({1'b1, req1Reg, req1Data});
        @(posedge clock);
        #1;
        checkVal("regWrite", {31'd0, regWrite}, {31'd0, (e0 | e1)});
        if ((e0 | e1) && expQ.size() > 0) begin
            word = expQ.pop_front();
            checkVal("writeWord", {21'd0, grantId, RegisterNumber, writeData}, {21'd0, word});
        end
        checkVal("state", {30'd0, dbgState}, {30'd0, expState});
        checkVal("busy", {31'd0, busy}, {31'd0, (expState != stIdle)});
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkVal({tag, "_regNum"}, {30'd0, RegisterNumber}, 32'd0);
        checkVal({tag, "_data"}, {24'd0, writeData}, 32'd0);
        checkVal({tag, "_grantId"}, {31'd0, grantId}, 32'd0);
        checkVal({tag, "_burstCnt"}, {29'd0, dbgBurstCnt}, 32'd0);
    endtask

    task automatic resetOneCycle();
        reset = 1'b0;
        drive(1, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
        cycle(0, 0, stIdle);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);

        // 1: reset held two cycles with both requesters valid
        drive(1, 0, 2'd1, 8'h55, 1, 0, 2'd2, 8'hAA);
        cycle(0, 0, stIdle);
        cycle(0, 0, stIdle);
        checkZeroOutputs("reset");
        reset = 1'b1;
        drive(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        cycle(0, 0, stIdle);

        // 2: single write from req0, then the output holds with regWrite low
        drive(1, 0, 2'd0, 8'h83, 0, 0, 2'd0, 8'h00);
        cycle(1, 0, stIdle);
        drive(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        cycle(0, 0, stIdle);
        checkVal("holdData", {24'd0, writeData}, 32'h83);
        checkVal("holdGrant", {31'd0, grantId}, 32'd0);

        // 3: both valid, no lock: alternate starting with req0 after reset
        resetOneCycle();
        drive(1, 0, 2'd1, 8'h11, 1, 0, 2'd3, 8'hF0);
        cycle(1, 0, stIdle);
        cycle(0, 1, stIdle);
        cycle(1, 0, stIdle);
        cycle(0, 1, stIdle);

        // 4: req0 locks for six writes; forced release after four, req1 gets one
        resetOneCycle();
        drive(1, 1, 2'd2, 8'hA0, 1, 0, 2'd1, 8'h5A);
        cycle(1, 0, stOwn0);
        drive(1, 1, 2'd2, 8'hA1, 1, 0, 2'd1, 8'h5A);
        cycle(1, 0, stOwn0);
        checkVal("burstCnt2", {29'd0, dbgBurstCnt}, 32'd2);
        drive(1, 1, 2'd2, 8'hA2, 1, 0, 2'd1, 8'h5A);
        cycle(1, 0, stOwn0);
        drive(1, 1, 2'd2, 8'hA3, 1, 0, 2'd1, 8'h5A);
        cycle(1, 0, stIdle);
        checkVal("burstRelease", {29'd0, dbgBurstCnt}, 32'd0);
        drive(1, 1, 2'd2, 8'hA4, 1, 0, 2'd1, 8'h5A);
        cycle(0, 1, stIdle);
        cycle(1, 0, stOwn0);

        // 5: OWN1, lock held blocks req0; dropping the lock hands req0 the same cycle
        resetOneCycle();
        drive(0, 0, 2'd0, 8'h00, 1, 1, 2'd3, 8'hC1);
        cycle(0, 1, stOwn1);
        drive(1, 0, 2'd2, 8'h0D, 1, 1, 2'd3, 8'hC2);
        cycle(0, 1, stOwn1);
        drive(1, 0, 2'd2, 8'h0E, 1, 0, 2'd3, 8'hC3);
        cycle(1, 0, stIdle);

        // 6: idle cycle inside a burst does not count; reset mid-burst clears everything
        resetOneCycle();
        drive(1, 1, 2'd1, 8'h61, 1, 0, 2'd0, 8'h71);
        cycle(1, 0, stOwn0);
        drive(1, 1, 2'd1, 8'h62, 1, 0, 2'd0, 8'h71);
        cycle(1, 0, stOwn0);
        drive(0, 1, 2'd1, 8'h63, 1, 0, 2'd0, 8'h71);
        cycle(0, 0, stOwn0);
        checkVal("idleNoCount", {29'd0, dbgBurstCnt}, 32'd2);
        reset = 1'b0;
        drive(1, 1, 2'd1, 8'h64, 1, 0, 2'd0, 8'h71);
        cycle(0, 0, stIdle);
        checkZeroOutputs("midReset");
        reset = 1'b1;
        drive(1, 0, 2'd1, 8'h65, 1, 0, 2'd0, 8'h72);
        cycle(1, 0, stIdle);

        checkVal("queueEmpty", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
